// File: rtl/shot_resolver_pkg.sv
// Shared types and helpers for the shot resolver: FSM state encoding, shot
// counter width and the widened single-axis overlap test.
package shot_resolver_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SHOT_CNT_W = 3;

    // Operands are masked to the axis width, then summed at 17 bits so a
    // hitbox straddling the right/bottom screen edge never wraps to zero.
    function automatic logic axis_overlap(
        input logic [15:0] pos,
        input logic [15:0] size,
        input logic [15:0] tgt,
        input logic [15:0] tgt_size,
        input int          width
    );
        logic [16:0] mask;
        logic [16:0] p;
        logic [16:0] t;
        mask = (17'd1 << width) - 17'd1;
        p    = {1'b0, pos} & mask;
        t    = {1'b0, tgt} & mask;
        return (p <= (t + {1'b0, tgt_size} - 17'd1)) &&
               ((p + {1'b0, size} - 17'd1) >= t);
    endfunction

endpackage

// File: rtl/shot_resolver_hitbox_overlap.sv
// Combinational 2-D overlap test between the square cursor and one bird
// hitbox, both given by their top-left corner.
module hitbox_overlap
    import shot_resolver_pkg::*;
#(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int BIRD_W    = 14,
    parameter int BIRD_H    = 9,
    parameter int CURSOR_SZ = 3
) (
    input  logic [X_W-1:0] cursor_x,
    input  logic [Y_W-1:0] cursor_y,
    input  logic [X_W-1:0] bird_x,
    input  logic [Y_W-1:0] bird_y,
    output logic           hit
);

    logic x_ov;
    logic y_ov;

    assign x_ov = axis_overlap(16'(cursor_x), 16'(CURSOR_SZ), 16'(bird_x), 16'(BIRD_W), X_W);
    assign y_ov = axis_overlap(16'(cursor_y), 16'(CURSOR_SZ), 16'(bird_y), 16'(BIRD_H), Y_W);
    assign hit  = x_ov & y_ov;

endmodule

// File: rtl/shot_resolver.sv
// Resolves trigger pulses against NUM_BIRDS hitboxes per round; tracks shots,
// sticky hits, escape and round completion. Define MULTI_HIT_EN to let one
// shot strike every overlapping bird instead of only the lowest index.
module shot_resolver
    import shot_resolver_pkg::*;
#(
    parameter int NUM_BIRDS       = 2,
    parameter int SHOTS_PER_ROUND = 3,
    parameter int X_W             = 8,
    parameter int Y_W             = 7,
    parameter int BIRD_W          = 14,
    parameter int BIRD_H          = 9,
    parameter int CURSOR_SZ       = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    round_start,
    input  logic                    trigger,
    input  logic [X_W-1:0]          cursor_x,
    input  logic [Y_W-1:0]          cursor_y,
    input  logic [NUM_BIRDS*X_W-1:0] bird_x,
    input  logic [NUM_BIRDS*Y_W-1:0] bird_y,
    input  logic [NUM_BIRDS-1:0]    bird_active,
    output logic [SHOT_CNT_W-1:0]   shots_left,
    output logic [NUM_BIRDS-1:0]    hit_mask,
    output logic                    hit_valid,
    output logic                    hit_any,
    output logic [2:0]              hit_idx,
    output logic                    escape,
    output logic                    round_done
);

    state_t                   state_r;
    state_t                   state_next_s;
    logic [SHOT_CNT_W-1:0]    shots_r;
    logic [NUM_BIRDS-1:0]     mask_r;
    logic                     hit_valid_r;
    logic                     hit_any_r;
    logic [2:0]               hit_idx_r;
    logic                     escape_r;
    logic                     done_r;

    logic [X_W-1:0]           snap_cx_r;
    logic [Y_W-1:0]           snap_cy_r;
    logic [NUM_BIRDS*X_W-1:0] snap_bx_r;
    logic [NUM_BIRDS*Y_W-1:0] snap_by_r;
    logic [NUM_BIRDS-1:0]     snap_act_r;

    logic [NUM_BIRDS-1:0]     overlap_s;
    logic [NUM_BIRDS-1:0]     cand_s;
    logic [NUM_BIRDS-1:0]     strike_s;
    logic [NUM_BIRDS-1:0]     new_mask_s;
    logic [SHOT_CNT_W-1:0]    new_shots_s;
    logic [2:0]               idx_s;
    logic                     found_s;
    logic                     all_hit_s;
    logic                     fire_s;

    genvar g;
    generate
        for (g = 0; g < NUM_BIRDS; g++) begin : g_hitbox
            hitbox_overlap #(
                .X_W      (X_W),
                .Y_W      (Y_W),
                .BIRD_W   (BIRD_W),
                .BIRD_H   (BIRD_H),
                .CURSOR_SZ(CURSOR_SZ)
            ) u_hitbox (
                .cursor_x(snap_cx_r),
                .cursor_y(snap_cy_r),
                .bird_x  (snap_bx_r[g*X_W +: X_W]),
                .bird_y  (snap_by_r[g*Y_W +: Y_W]),
                .hit     (overlap_s[g])
            );
        end
    endgenerate

    assign cand_s = overlap_s & snap_act_r & ~mask_r;
    assign fire_s = (state_r == ARMED) && trigger && !round_start &&
                    (shots_r != {SHOT_CNT_W{1'b0}});

    // Lowest-index priority encoder over the candidate set.
    always_comb begin
        idx_s    = 3'd0;
        found_s  = 1'b0;
        strike_s = {NUM_BIRDS{1'b0}};
        for (int i = 0; i < NUM_BIRDS; i++) begin
            if (cand_s[i] && !found_s) begin
                found_s = 1'b1;
                idx_s   = 3'(i);
`ifndef MULTI_HIT_EN
                strike_s[i] = 1'b1;
`endif
            end else begin
                found_s = found_s;
            end
        end
`ifdef MULTI_HIT_EN
        strike_s = cand_s;
`endif
    end

    assign new_mask_s  = mask_r | strike_s;
    assign new_shots_s = shots_r - {{(SHOT_CNT_W-1){1'b0}}, 1'b1};
    assign all_hit_s   = &new_mask_s;

    // Next-state logic; round_start overrides every state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = IDLE;
            ARMED:   state_next_s = fire_s ? RESOLVE : ARMED;
            RESOLVE: begin
                if (all_hit_s || (new_shots_s == {SHOT_CNT_W{1'b0}})) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ARMED;
                end
            end
            DONE:    state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
        if (round_start) begin
            state_next_s = ARMED;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Snapshot of cursor and birds taken when a shot is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_cx_r  <= '0;
            snap_cy_r  <= '0;
            snap_bx_r  <= '0;
            snap_by_r  <= '0;
            snap_act_r <= '0;
        end else if (fire_s) begin
            snap_cx_r  <= cursor_x;
            snap_cy_r  <= cursor_y;
            snap_bx_r  <= bird_x;
            snap_by_r  <= bird_y;
            snap_act_r <= bird_active;
        end
    end

    // Round bookkeeping and the registered shot-result pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shots_r     <= '0;
            mask_r      <= '0;
            hit_valid_r <= 1'b0;
            hit_any_r   <= 1'b0;
            hit_idx_r   <= 3'd0;
            escape_r    <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            hit_valid_r <= 1'b0;
            hit_any_r   <= 1'b0;
            hit_idx_r   <= 3'd0;
            if (round_start) begin
                shots_r  <= SHOT_CNT_W'(SHOTS_PER_ROUND);
                mask_r   <= '0;
                escape_r <= 1'b0;
                done_r   <= 1'b0;
            end else if (state_r == RESOLVE) begin
                shots_r     <= new_shots_s;
                mask_r      <= new_mask_s;
                hit_valid_r <= 1'b1;
                hit_any_r   <= found_s;
                hit_idx_r   <= found_s ? idx_s : 3'd0;
                if (all_hit_s) begin
                    done_r <= 1'b1;
                end else if (new_shots_s == {SHOT_CNT_W{1'b0}}) begin
                    done_r   <= 1'b1;
                    escape_r <= 1'b1;
                end
            end
        end
    end

    assign shots_left = shots_r;
    assign hit_mask   = mask_r;
    assign hit_valid  = hit_valid_r;
    assign hit_any    = hit_any_r;
    assign hit_idx    = hit_idx_r;
    assign escape     = escape_r;
    assign round_done = done_r;

endmodule

// File: tb/tb_shot_resolver.sv
// Scoreboard bench for shot_resolver with directed shots; expectations are
// queued at trigger time and checked by a monitor whenever hit_valid fires.
module tb_shot_resolver;

    logic        clk;
    logic        reset_n;
    logic        round_start;
    logic        trigger;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic [15:0] bird_x;
    logic [13:0] bird_y;
    logic [1:0]  bird_active;
    logic [2:0]  shots_left;
    logic [1:0]  hit_mask;
    logic        hit_valid;
    logic        hit_any;
    logic [2:0]  hit_idx;
    logic        escape;
    logic        round_done;

    typedef struct {
        int         cyc;
        logic       any;
        logic [2:0] idx;
        logic [1:0] mask;
        logic [2:0] shots;
        logic       done;
        logic       esc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;

    shot_resolver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .round_start(round_start),
        .trigger    (trigger),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .bird_x     (bird_x),
        .bird_y     (bird_y),
        .bird_active(bird_active),
        .shots_left (shots_left),
        .hit_mask   (hit_mask),
        .hit_valid  (hit_valid),
        .hit_any    (hit_any),
        .hit_idx    (hit_idx),
        .escape     (escape),
        .round_done (round_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every hit_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (hit_valid === 1'b1) begin
            if (q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_hit_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("latency_cycle", cyc, mon_e.cyc);
                chk("hit_any", {31'd0, hit_any}, {31'd0, mon_e.any});
                if (mon_e.any) chk("hit_idx", {29'd0, hit_idx}, {29'd0, mon_e.idx});
                chk("hit_mask", {30'd0, hit_mask}, {30'd0, mon_e.mask});
                chk("shots_left", {29'd0, shots_left}, {29'd0, mon_e.shots});
                chk("round_done", {31'd0, round_done}, {31'd0, mon_e.done});
                chk("escape", {31'd0, escape}, {31'd0, mon_e.esc});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rs();
        round_start = 1'b1;
        tick(1);
        round_start = 1'b0;
    endtask

    task automatic set_scene(input logic [7:0] cx, input logic [6:0] cy,
                             input logic [7:0] b0x, input logic [6:0] b0y,
                             input logic [7:0] b1x, input logic [6:0] b1y,
                             input logic [1:0] act);
        cursor_x    = cx;
        cursor_y    = cy;
        bird_x      = {b1x, b0x};
        bird_y      = {b1y, b0y};
        bird_active = act;
    endtask

    // Fire one shot on the current scene; queue the expectation when exp_on.
    task automatic shot(input logic exp_on, input logic any, input logic [2:0] idx,
                        input logic [1:0] mask, input logic [2:0] shots,
                        input logic done, input logic esc);
        exp_t e;
        trigger = 1'b1;
        if (exp_on) begin
            e.cyc = cyc + 2; e.any = any; e.idx = idx; e.mask = mask;
            e.shots = shots; e.done = done; e.esc = esc;
            q.push_back(e);
        end
        tick(1);
        trigger = 1'b0;
        tick(2);
    endtask

    initial begin
        reset_n = 1'b0; round_start = 1'b0; trigger = 1'b0;
        set_scene(8'd0, 7'd0, 8'd0, 7'd0, 8'd0, 7'd0, 2'b00);
        tick(2);
        chk("rst_shots", {29'd0, shots_left}, 32'd0);
        chk("rst_mask", {30'd0, hit_mask}, 32'd0);
        chk("rst_valid", {31'd0, hit_valid}, 32'd0);
        chk("rst_any_idx", {28'd0, hit_any, hit_idx}, 32'd0);
        chk("rst_esc_done", {30'd0, escape, round_done}, 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Trigger while IDLE is ignored.
        shot(1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk("idle_shots", {29'd0, shots_left}, 32'd0);

        // Basic hit on bird 0.
        rs();
        chk("reload_shots", {29'd0, shots_left}, 32'd3);
        set_scene(8'd50, 7'd20, 8'd45, 7'd15, 8'd200, 7'd100, 2'b11);
        shot(1'b1, 1'b1, 3'd0, 2'b01, 3'd2, 1'b0, 1'b0);

        // Three misses lead to escape.
        rs();
        set_scene(8'd0, 7'd0, 8'd100, 7'd50, 8'd100, 7'd50, 2'b11);
        shot(1'b1, 1'b0, 3'd0, 2'b00, 3'd2, 1'b0, 1'b0);
        shot(1'b1, 1'b0, 3'd0, 2'b00, 3'd1, 1'b0, 1'b0);
        shot(1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 1'b1, 1'b1);
        chk("escape_level", {30'd0, escape, round_done}, 32'd3);
        shot(1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk("done_holds", {29'd0, shots_left}, 32'd0);

        // Two overlapping birds.
        rs();
        chk("restart_clear", {30'd0, escape, round_done}, 32'd0);
        set_scene(8'd30, 7'd30, 8'd28, 7'd25, 8'd28, 7'd25, 2'b11);
`ifdef MULTI_HIT_EN
        shot(1'b1, 1'b1, 3'd0, 2'b11, 3'd2, 1'b1, 1'b0);
`else
        shot(1'b1, 1'b1, 3'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        shot(1'b1, 1'b1, 3'd1, 2'b11, 3'd1, 1'b1, 1'b0);
`endif
        chk("all_hit_done", {30'd0, escape, round_done}, 32'd1);

        // Inactive bird is not a candidate.
        rs();
        set_scene(8'd30, 7'd30, 8'd28, 7'd25, 8'd200, 7'd100, 2'b10);
        shot(1'b1, 1'b0, 3'd0, 2'b00, 3'd2, 1'b0, 1'b0);

        // Right-edge straddle hits without wrap; far-left cursor misses.
        set_scene(8'd254, 7'd10, 8'd250, 7'd5, 8'd0, 7'd100, 2'b11);
        shot(1'b1, 1'b1, 3'd0, 2'b01, 3'd1, 1'b0, 1'b0);
        set_scene(8'd5, 7'd10, 8'd0, 7'd100, 8'd250, 7'd5, 2'b11);
        shot(1'b1, 1'b0, 3'd0, 2'b01, 3'd0, 1'b1, 1'b1);

        // round_start coincident with trigger: trigger dropped.
        set_scene(8'd30, 7'd30, 8'd28, 7'd25, 8'd28, 7'd25, 2'b11);
        round_start = 1'b1;
        trigger     = 1'b1;
        tick(1);
        round_start = 1'b0;
        trigger     = 1'b0;
        chk("rs_trig_shots", {29'd0, shots_left}, 32'd3);
        chk("rs_trig_clear", {28'd0, hit_mask, escape, round_done}, 32'd0);
        tick(3);
        chk("rs_trig_after", {27'd0, shots_left, hit_mask}, {27'd0, 3'd3, 2'b00});

        // Reset asserted while RESOLVE is in flight.
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_shots", {29'd0, shots_left}, 32'd0);
        chk("mid_rst_mask", {30'd0, hit_mask}, 32'd0);
        chk("mid_rst_pulse", {27'd0, hit_valid, hit_any, hit_idx}, 32'd0);
        chk("mid_rst_status", {30'd0, escape, round_done}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(3);
        chk("post_rst_idle", {27'd0, shots_left, hit_mask}, 32'd0);

        tick(2);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
